// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the execute-stage pipeline control of the 5-stage core.
//   - Bit positions of the one-hot instruction-type vector carried in ID/EX.
//   - Operand forwarding select encodings used by the ALU input muxes.
//   - State encoding of the execute-stage hazard controller.
// -----------------------------------------------------------------------------
package core_pkg;

    // One-hot instruction type bit indices
    localparam int INS_R      = 0;
    localparam int INS_I      = 1;
    localparam int INS_STORE  = 2;
    localparam int INS_LOAD   = 3;
    localparam int INS_BRANCH = 4;
    localparam int INS_LUI    = 5;
    localparam int INS_AUIPC  = 6;
    localparam int INS_JAL    = 7;
    localparam int INS_JALR   = 8;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Purely combinational forwarding selector for one ALU operand.
// Ports:
//   rs               in  5  source register read by the instruction in EX
//   ex_mem_rd        in  5  destination register of the instruction in MEM
//   ex_mem_regwrite  in  1  instruction in MEM writes the register file
//   mem_wb_rd        in  5  destination register of the instruction in WB
//   mem_wb_regwrite  in  1  instruction in WB writes the register file
//   sel              out 2  FWD_RF / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_sel
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_regwrite,
    input  logic [4:0] mem_wb_rd,
    input  logic       mem_wb_regwrite,
    output logic [1:0] sel
);

    // The younger result (EX/MEM) wins; x0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// ex_hazard_ctrl
// Execute-stage pipeline controller: advance/hold/bubble of ID/EX, operand
// forwarding selects, redirect flush sequencing and data-memory freeze.
// Ports:
//   clk, rst (sync, active-low)
//   if_id_rs1/rs2            in  5   sources of the instruction in ID
//   id_ex_valid/instype      in  1/9 instruction in EX is real / one-hot type
//   id_ex_rs1/rs2/rd         in  5   register fields of the instruction in EX
//   ex_mem_rd/_regwrite      in  5/1 MEM stage destination
//   mem_wb_rd/_regwrite      in  5/1 WB stage destination
//   branch_taken             in  1   EX resolved a redirect
//   mem_busy                 in  1   data memory stalled
//   stall_if/stall_id        out 1   hold PC and IF/ID
//   bubble_ex                out 1   load NOP into ID/EX
//   flush_id                 out 1   invalidate IF/ID
//   freeze                   out 1   hold ID/EX, EX/MEM, MEM/WB
//   redirect                 out 1   PC takes the EX target
//   fwd_a/fwd_b              out 2   ALU operand source selects
//   mem_timeout              out 1   sticky memory-wait timeout
//   stall_count/flush_count  out CNT_W saturating event counters
// -----------------------------------------------------------------------------
module ex_hazard_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 15,
    parameter int CNT_W        = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_valid,
    input  logic [8:0]       id_ex_instype,
    input  logic [4:0]       id_ex_rs1,
    input  logic [4:0]       id_ex_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       ex_mem_rd,
    input  logic [4:0]       mem_wb_rd,
    input  logic             ex_mem_regwrite,
    input  logic             mem_wb_regwrite,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze,
    output logic             redirect,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam state_e            REDIR_ST   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_e            state_q, state_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              redirect_pend_q, redirect_pend_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic       br_fire;
    logic       load_use;
    logic       stall_r, bubble_r, flush_r, freeze_r, redirect_r;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       unused_instype;

    assign br_fire  = branch_taken & id_ex_valid;
    assign load_use = id_ex_valid & id_ex_instype[INS_LOAD] & (id_ex_rd != 5'd0) &
                      ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    // Only the load bit matters here; redirect qualification is done upstream.
    assign unused_instype = ^{id_ex_instype[8:4], id_ex_instype[2:0]};

    fwd_sel u_fwd_a (
        .rs              (id_ex_rs1),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .rs              (id_ex_rs2),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (fwd_b_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= RUN;
            flush_cnt_q     <= '0;
            wait_cnt_q      <= '0;
            redirect_pend_q <= 1'b0;
            mem_timeout_q   <= 1'b0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            redirect_pend_q <= redirect_pend_d;
            mem_timeout_q   <= mem_timeout_d;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        redirect_pend_d = redirect_pend_q;
        mem_timeout_d   = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d         = MWAIT;
                    // EX is frozen, so a redirect resolved now must not be lost.
                    redirect_pend_d = br_fire;
                end else if (br_fire) begin
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = REDIR_ST;
                end
            end
            MWAIT: begin
                if (mem_busy) begin
                    if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q >= WAIT_LAST) mem_timeout_d = 1'b1;
                    if (br_fire) redirect_pend_d = 1'b1;
                end else begin
                    wait_cnt_d      = '0;
                    redirect_pend_d = 1'b0;
                    if (redirect_pend_q || br_fire) begin
                        flush_cnt_d = FLUSH_INIT;
                        state_d     = REDIR_ST;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                // A frozen pipe does not consume flush slots.
                if (!mem_busy) begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q <= 2'd1) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        stall_count_d = stall_count_q;
        if (stall_r && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CNT_W'(1);
        flush_count_d = flush_count_q;
        if (redirect_r && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_comb begin
        stall_r    = 1'b0;
        bubble_r   = 1'b0;
        flush_r    = 1'b0;
        freeze_r   = 1'b0;
        redirect_r = 1'b0;
        case (state_q)
            RUN, MWAIT: begin
                if (mem_busy) begin
                    freeze_r = 1'b1;
                    stall_r  = 1'b1;
                end else if (br_fire || (state_q == MWAIT && redirect_pend_q)) begin
                    redirect_r = 1'b1;
                    flush_r    = 1'b1;
                    bubble_r   = 1'b1;
                end else if (load_use) begin
                    // The cycle memory releases behaves as an ordinary RUN cycle.
                    stall_r  = 1'b1;
                    bubble_r = 1'b1;
                end
            end
            FLUSH: begin
                flush_r  = 1'b1;
                bubble_r = 1'b1;
                if (mem_busy) begin
                    freeze_r = 1'b1;
                    stall_r  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // While reset is held the pipe is kept empty and nothing is redirected.
    assign stall_if    = rst & stall_r;
    assign stall_id    = rst & stall_r;
    assign bubble_ex   = ~rst | bubble_r;
    assign flush_id    = ~rst | flush_r;
    assign freeze      = rst & freeze_r;
    assign redirect    = rst & redirect_r;
    assign fwd_a       = rst ? fwd_a_raw : FWD_RF;
    assign fwd_b       = rst ? fwd_b_raw : FWD_RF;
    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int EXP_W = 11 + 2 * CNT_W;
    localparam logic [8:0] T_R    = 9'h001;
    localparam logic [8:0] T_LOAD = 9'h008;
    localparam logic [8:0] T_BR   = 9'h010;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs1, if_id_rs2;
    logic             id_ex_valid;
    logic [8:0]       id_ex_instype;
    logic [4:0]       id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [4:0]       ex_mem_rd, mem_wb_rd;
    logic             ex_mem_regwrite, mem_wb_regwrite;
    logic             branch_taken, mem_busy;
    logic             stall_if, stall_id, bubble_ex, flush_id, freeze, redirect;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct {
        string            tag;
        logic [EXP_W-1:0] v;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_sc = '0;
    logic [CNT_W-1:0] exp_fc = '0;
    logic             exp_to = 1'b0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_instype(id_ex_instype),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .freeze(freeze), .redirect(redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic clr_inputs();
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_valid = 1'b0; id_ex_instype = T_R;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        ex_mem_rd = '0; mem_wb_rd = '0; ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // ctl = {stall_if, stall_id, bubble_ex, flush_id, freeze, redirect}
    task automatic push_exp(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                            input logic [1:0] fb);
        exp_t e;
        e.tag = tag;
        e.v   = {ctl, fa, fb, exp_to, exp_sc, exp_fc};
        sb.push_back(e);
        if (ctl[5] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
        if (ctl[0] && exp_fc != '1) exp_fc = exp_fc + 1'b1;
    endtask

    task automatic tick();
        exp_t             e;
        logic [EXP_W-1:0] obs;
        @(negedge clk);
        obs = {stall_if, stall_id, bubble_ex, flush_id, freeze, redirect,
               fwd_a, fwd_b, mem_timeout, stall_count, flush_count};
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb);
        push_exp(tag, ctl, fa, fb);
        tick();
    endtask

    initial begin
        clr_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs forced even with forwarding/branch conditions present
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; id_ex_rs1 = 5'd5;
        id_ex_valid = 1'b1; id_ex_instype = T_BR; branch_taken = 1'b1;
        step("rst_state", 6'b001100, 2'b00, 2'b00);
        rst = 1'b1;
        clr_inputs();
        step("idle", 6'b000000, 2'b00, 2'b00);

        // Forwarding
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd6;
        step("fwd_exmem", 6'b000000, 2'b01, 2'b00);
        mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1; id_ex_rs2 = 5'd0;
        step("fwd_both_prio", 6'b000000, 2'b01, 2'b00);
        ex_mem_rd = 5'd9; mem_wb_rd = 5'd6; id_ex_rs1 = 5'd9; id_ex_rs2 = 5'd6;
        step("fwd_memwb", 6'b000000, 2'b01, 2'b10);
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0;
        step("fwd_x0", 6'b000000, 2'b00, 2'b00);
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b0; mem_wb_rd = 5'd5; id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd5;
        step("fwd_nowrite", 6'b000000, 2'b10, 2'b10);
        clr_inputs();

        // Load-use
        id_ex_valid = 1'b1; id_ex_instype = T_LOAD; id_ex_rd = 5'd3; if_id_rs1 = 5'd1; if_id_rs2 = 5'd3;
        step("lu_stall", 6'b111000, 2'b00, 2'b00);
        id_ex_instype = T_R; id_ex_rd = 5'd4;
        step("lu_release", 6'b000000, 2'b00, 2'b00);
        id_ex_instype = T_LOAD; id_ex_rd = 5'd0; if_id_rs1 = 5'd0;
        step("lu_x0", 6'b000000, 2'b00, 2'b00);
        id_ex_valid = 1'b0; id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
        step("lu_invalid", 6'b000000, 2'b00, 2'b00);
        id_ex_valid = 1'b1;
        step("lu_rs1", 6'b111000, 2'b00, 2'b00);
        clr_inputs();

        // Taken branch with two flush cycles
        id_ex_valid = 1'b1; id_ex_instype = T_BR; branch_taken = 1'b1;
        step("br_redirect", 6'b001101, 2'b00, 2'b00);
        step("br_flush_ignores_br", 6'b001100, 2'b00, 2'b00);
        clr_inputs();
        step("br_back_run", 6'b000000, 2'b00, 2'b00);

        // Memory busy 3 cycles, branch resolved in the second busy cycle
        mem_busy = 1'b1;
        step("mb_busy1", 6'b110010, 2'b00, 2'b00);
        id_ex_valid = 1'b1; id_ex_instype = T_BR; branch_taken = 1'b1;
        step("mb_busy2_br", 6'b110010, 2'b00, 2'b00);
        id_ex_valid = 1'b0; branch_taken = 1'b0;
        step("mb_busy3", 6'b110010, 2'b00, 2'b00);
        mem_busy = 1'b0;
        step("mb_pend_redirect", 6'b001101, 2'b00, 2'b00);
        step("mb_flush", 6'b001100, 2'b00, 2'b00);
        step("mb_back_run", 6'b000000, 2'b00, 2'b00);

        // Memory busy during FLUSH holds the flush slot
        id_ex_valid = 1'b1; id_ex_instype = T_BR; branch_taken = 1'b1;
        step("fb_redirect", 6'b001101, 2'b00, 2'b00);
        clr_inputs();
        mem_busy = 1'b1;
        step("fb_frozen", 6'b111110, 2'b00, 2'b00);
        mem_busy = 1'b0;
        step("fb_flush_resume", 6'b001100, 2'b00, 2'b00);
        step("fb_back_run", 6'b000000, 2'b00, 2'b00);

        // Reset in the middle of FLUSH
        id_ex_valid = 1'b1; id_ex_instype = T_BR; branch_taken = 1'b1;
        step("rm_redirect", 6'b001101, 2'b00, 2'b00);
        rst = 1'b0; mem_busy = 1'b1;
        step("rm_in_reset", 6'b001100, 2'b00, 2'b00);
        exp_sc = '0; exp_fc = '0; exp_to = 1'b0;
        rst = 1'b1;
        clr_inputs();
        step("rm_after_reset", 6'b000000, 2'b00, 2'b00);

        // Timeout: 20 busy cycles, stall_count saturates along the way
        mem_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            exp_to = (k >= 17);
            step($sformatf("to_busy%0d", k), 6'b110010, 2'b00, 2'b00);
        end
        mem_busy = 1'b0;
        exp_to = 1'b1;
        step("to_exit", 6'b000000, 2'b00, 2'b00);
        step("to_sticky", 6'b000000, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
